// File: rtl/vermi_data_memory_if.sv
// Data-port bus between the core's load/store unit and the data memory.
// The core drives the request fields and holds them with valid until ready.
interface vermi_data_memory_if;
  logic        valid;
  logic        ready;
  logic [31:0] address;
  logic [3:0]  wstrobe;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        error;

  modport master (
    output valid,
    output address,
    output wstrobe,
    output wdata,
    input  ready,
    input  rdata,
    input  error
  );

  modport slave (
    input  valid,
    input  address,
    input  wstrobe,
    input  wdata,
    output ready,
    output rdata,
    output error
  );
endinterface

// File: rtl/vermi_data_memory.sv
// Word-organised data memory on the core's load/store port: byte-lane writes,
// read-before-write word reads, programmable wait states and range checking.
module vermi_data_memory #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int unsigned SIZE         = 1024,
  parameter int unsigned WAIT_STATES  = 0
) (
  input  logic               clk,
  input  logic               reset,
  vermi_data_memory_if.slave bus
);

  localparam int          IDX_W   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [31:0] SIZE_W  = 32'(SIZE);
  localparam logic [7:0]  WS_INIT = 8'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Replace the strobed byte lanes of a stored word with the new data.
  function automatic logic [31:0] merge_lanes(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [31:0] mem_r [SIZE];

  state_t      state_r;
  state_t      state_next_s;
  logic [7:0]  cnt_r;
  logic [7:0]  cnt_next_s;
  logic        access_s;
  logic        ready_r;
  logic        error_r;
  logic [31:0] rdata_r;

  logic [31:0] offset_s;
  logic [31:0] index_s;
  logic        in_range_s;
  logic [IDX_W-1:0] word_idx_s;
  logic [31:0] read_word_s;
  logic        do_write_s;

  // Address decode; the subtraction wraps for addresses below the base, which
  // the explicit lower-bound compare rejects.
  always_comb begin
    offset_s    = bus.address - BASE_ADDRESS;
    index_s     = offset_s >> 2;
    in_range_s  = (bus.address >= BASE_ADDRESS) && (index_s < SIZE_W);
    word_idx_s  = index_s[IDX_W-1:0];
    read_word_s = mem_r[word_idx_s];
    do_write_s  = access_s && in_range_s && (bus.wstrobe != 4'b0000) && !reset;
  end

  // Next-state logic. RESP re-arms straight into WAIT when valid is still
  // held, which gives back-to-back readies a spacing of 2 + WAIT_STATES.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    access_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.valid) begin
          state_next_s = ST_WAIT;
          cnt_next_s   = WS_INIT;
        end else begin
          state_next_s = ST_IDLE;
          cnt_next_s   = 8'd0;
        end
      end
      ST_WAIT: begin
        if (!bus.valid) begin
          state_next_s = ST_IDLE;
          cnt_next_s   = 8'd0;
        end else if (cnt_r == 8'd0) begin
          access_s     = 1'b1;
          state_next_s = ST_RESP;
        end else begin
          cnt_next_s   = cnt_r - 8'd1;
        end
      end
      ST_RESP: begin
        if (bus.valid) begin
          state_next_s = ST_WAIT;
          cnt_next_s   = WS_INIT;
        end else begin
          state_next_s = ST_IDLE;
          cnt_next_s   = 8'd0;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = 8'd0;
      end
    endcase
  end

  // State, wait counter and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      ready_r <= 1'b0;
      error_r <= 1'b0;
      rdata_r <= 32'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      ready_r <= access_s;
      error_r <= access_s && !in_range_s;
      if (access_s) begin
        rdata_r <= in_range_s ? read_word_s : 32'd0;
      end
    end
  end

  // Byte-lane write port; the array contents survive reset.
  always_ff @(posedge clk) begin
    if (do_write_s) begin
      mem_r[word_idx_s] <= merge_lanes(read_word_s, bus.wdata, bus.wstrobe);
    end
  end

  assign bus.ready = ready_r;
  assign bus.error = error_r;
  assign bus.rdata = rdata_r;

endmodule

// File: tb/tb_vermi_data_memory.sv
// Scoreboard bench for vermi_data_memory: one instance with zero wait states at
// base 0, one with three wait states at base 0x1000 for range and abort cases.
module tb_vermi_data_memory;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    bit          chk_rd;
  } exp_t;

  logic clk;
  logic rst0;
  logic rst1;
  int   cyc;
  int   checks;
  int   failures;
  bit   mon_en;

  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] model0 [int];
  logic [31:0] model1 [int];

  vermi_data_memory_if bus0();
  vermi_data_memory_if bus1();

  vermi_data_memory #(
    .BASE_ADDRESS(32'h0000_0000), .SIZE(1024), .WAIT_STATES(0)
  ) u_dut0 (
    .clk(clk), .reset(rst0), .bus(bus0)
  );

  vermi_data_memory #(
    .BASE_ADDRESS(32'h0000_1000), .SIZE(1024), .WAIT_STATES(3)
  ) u_dut1 (
    .clk(clk), .reset(rst1), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [31:0] addr,
                       input logic [3:0] strb, input logic [31:0] wd);
    if (sel == 0) begin
      bus0.valid = v; bus0.address = addr; bus0.wstrobe = strb; bus0.wdata = wd;
    end else begin
      bus1.valid = v; bus1.address = addr; bus1.wstrobe = strb; bus1.wdata = wd;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? bus0.ready : bus1.ready;
  endfunction

  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 0) ? bus0.rdata : bus1.rdata;
  endfunction

  // Compute the expected response from the reference word model and update it.
  task automatic push_exp(input int sel, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] wd);
    exp_t        e;
    logic [31:0] base;
    logic [31:0] idx;
    logic [31:0] old;
    logic [31:0] mask;
    bit          known;
    base     = (sel == 0) ? 32'h0000_0000 : 32'h0000_1000;
    idx      = (addr - base) >> 2;
    e.err    = 1'b0;
    e.rd     = 32'd0;
    e.chk_rd = 1'b1;
    if ((addr < base) || (idx >= 32'd1024)) begin
      e.err = 1'b1;
    end else begin
      known    = (sel == 0) ? model0.exists(int'(idx)) : model1.exists(int'(idx));
      old      = 32'd0;
      if (known) old = (sel == 0) ? model0[int'(idx)] : model1[int'(idx)];
      e.rd     = old;
      e.chk_rd = known;
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      if ((strb != 4'b0000) && (known || (strb == 4'b1111))) begin
        if (sel == 0) model0[int'(idx)] = (old & ~mask) | (wd & mask);
        else          model1[int'(idx)] = (old & ~mask) | (wd & mask);
      end
    end
    if (sel == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  task automatic score(input int sel, input logic rdy, input logic err, input logic [31:0] rd);
    exp_t e;
    int   sz;
    if (rdy === 1'b1) begin
      sz = (sel == 0) ? q0.size() : q1.size();
      check_eq($sformatf("sb_pending%0d", sel), 32'(sz != 0), 32'd1);
      if (sz != 0) begin
        if (sel == 0) e = q0.pop_front();
        else          e = q1.pop_front();
        check_eq($sformatf("error%0d", sel), {31'd0, err}, {31'd0, e.err});
        if (e.chk_rd) check_eq($sformatf("rdata%0d", sel), rd, e.rd);
      end
    end else begin
      check_eq($sformatf("error_idle%0d", sel), {31'd0, err}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      score(0, bus0.ready, bus0.error, bus0.rdata);
      score(1, bus1.ready, bus1.error, bus1.rdata);
    end
  end

  // One request: record expectation, drive, wait (bounded) for ready.
  task automatic do_req(input int sel, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wd, input bit keep,
                        output int start, output int rdy_cyc, output logic [31:0] got_rd);
    bit seen;
    push_exp(sel, addr, strb, wd);
    @(posedge clk); #1;
    drive(sel, 1'b1, addr, strb, wd);
    start   = cyc;
    seen    = 1'b0;
    rdy_cyc = -1;
    got_rd  = 32'd0;
    for (int n = 0; n < 64 && !seen; n++) begin
      @(negedge clk);
      if (get_ready(sel) === 1'b1) begin
        seen    = 1'b1;
        rdy_cyc = cyc;
        got_rd  = get_rdata(sel);
      end
    end
    check_eq($sformatf("ready_seen%0d", sel), {31'd0, seen}, 32'd1);
    if (!keep) begin
      @(posedge clk); #1;
      drive(sel, 1'b0, addr, 4'b0000, 32'd0);
    end
  endtask

  initial begin
    int s, r, r1, d;
    logic [31:0] rd, rd1;
    checks = 0; failures = 0; mon_en = 1'b0; cyc = 0;
    rst0 = 1'b1; rst1 = 1'b1;
    drive(0, 1'b0, 32'd0, 4'b0000, 32'd0);
    drive(1, 1'b0, 32'd0, 4'b0000, 32'd0);
    repeat (2) @(posedge clk);
    #1; rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    check_eq("rst_ready0", {31'd0, bus0.ready}, 32'd0);
    check_eq("rst_error0", {31'd0, bus0.error}, 32'd0);
    check_eq("rst_rdata0", bus0.rdata, 32'd0);
    check_eq("rst_ready1", {31'd0, bus1.ready}, 32'd0);
    check_eq("rst_error1", {31'd0, bus1.error}, 32'd0);
    check_eq("rst_rdata1", bus1.rdata, 32'd0);
    mon_en = 1'b1;

    // Zero wait states: basic reads, full and partial writes.
    do_req(0, 32'h10, 4'b1111, 32'h0000_0000, 1'b0, s, r, rd);
    do_req(0, 32'h10, 4'b0000, 32'hFFFF_FFFF, 1'b0, s, r, rd);
    check_eq("lat_ws0", 32'(r - s), 32'd2);
    check_eq("rd_0x10", rd, 32'h0000_0000);
    do_req(0, 32'h20, 4'b1111, 32'hDEAD_BEEF, 1'b0, s, r, rd);
    do_req(0, 32'h20, 4'b0000, 32'd0, 1'b0, s, r, rd);
    check_eq("rd_full", rd, 32'hDEAD_BEEF);
    do_req(0, 32'h20, 4'b0010, 32'h5555_5555, 1'b0, s, r, rd);
    check_eq("rbw_prior", rd, 32'hDEAD_BEEF);
    do_req(0, 32'h20, 4'b0000, 32'd0, 1'b0, s, r, rd);
    check_eq("rd_lane1", rd, 32'hDEAD_55EF);
    do_req(0, 32'h20, 4'b1100, 32'h1234_1234, 1'b0, s, r, rd);
    do_req(0, 32'h20, 4'b0000, 32'd0, 1'b0, s, r, rd);
    check_eq("rd_lane32", rd, 32'h1234_55EF);
    do_req(0, 32'h10, 4'b0000, 32'd0, 1'b1, s, r1, rd1);
    do_req(0, 32'h20, 4'b0000, 32'd0, 1'b0, s, r, rd);
    check_eq("b2b_gap_ws0", 32'(r - r1), 32'd2);

    // Offset base, three wait states: range edges and aliasing.
    do_req(1, 32'h1000, 4'b1111, 32'hCAFE_0001, 1'b0, s, r, rd);
    check_eq("lat_ws3", 32'(r - s), 32'd5);
    do_req(1, 32'h1FFC, 4'b1111, 32'h0BAD_F00D, 1'b0, s, r, rd);
    do_req(1, 32'h0FFC, 4'b1111, 32'h1111_1111, 1'b0, s, r, rd);
    check_eq("oor_low_rdata", rd, 32'd0);
    do_req(1, 32'h2000, 4'b1111, 32'h2222_2222, 1'b0, s, r, rd);
    do_req(1, 32'hFFFF_FFFC, 4'b0101, 32'h3333_3333, 1'b0, s, r, rd);
    do_req(1, 32'h1000, 4'b0000, 32'd0, 1'b1, s, r1, rd1);
    check_eq("b2b_first_lat", 32'(r1 - s), 32'd5);
    do_req(1, 32'h1FFC, 4'b0000, 32'd0, 1'b0, s, r, rd);
    check_eq("b2b_gap_ws3", 32'(r - r1), 32'd5);
    check_eq("no_alias_lo", rd1, 32'hCAFE_0001);
    check_eq("no_alias_hi", rd, 32'h0BAD_F00D);

    // Reset two cycles into a write.
    do_req(1, 32'h1100, 4'b1111, 32'hAAAA_0000, 1'b0, s, r, rd);
    @(posedge clk); #1;
    drive(1, 1'b1, 32'h1100, 4'b1111, 32'h5555_5555);
    repeat (2) begin @(posedge clk); #1; end
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    drive(1, 1'b0, 32'h1100, 4'b0000, 32'd0);
    @(negedge clk);
    check_eq("abort_rst_ready", {31'd0, bus1.ready}, 32'd0);
    check_eq("abort_rst_rdata", bus1.rdata, 32'd0);
    do_req(1, 32'h1100, 4'b0000, 32'd0, 1'b0, s, r, rd);
    check_eq("post_rst_lat", 32'(r - s), 32'd5);
    check_eq("post_rst_word", rd, 32'hAAAA_0000);

    // valid dropped two cycles into a write.
    @(posedge clk); #1;
    drive(1, 1'b1, 32'h1100, 4'b1111, 32'h7777_7777);
    repeat (2) begin @(posedge clk); #1; end
    drive(1, 1'b0, 32'h1100, 4'b0000, 32'd0);
    repeat (6) @(negedge clk);
    check_eq("abort_rdata_hold", bus1.rdata, 32'hAAAA_0000);
    do_req(1, 32'h1100, 4'b0000, 32'd0, 1'b0, s, r, rd);
    check_eq("post_drop_word", rd, 32'hAAAA_0000);

    repeat (4) @(negedge clk);
    check_eq("sb_drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
